// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain ps2c/ps2d.
// Requests to send, shifts {parity, byte} out on device clock falls, then checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2d,
  inout  wire        ps2c,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RTS   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_ACK   = 3'd5;
  localparam logic [2:0] S_WREL  = 3'd6;
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [2:0]    r_state;
  logic [1:0]    r_c_sync, r_d_sync;
  logic          r_c_filt;
  logic [FW-1:0] r_fcnt;
  logic [31:0]   r_cnt;
  logic [8:0]    r_sr;
  logic [3:0]    r_bit;
  logic          r_c_low, r_d_low, r_done, r_err;
  logic          w_fall, w_d;

  // Lines are only ever pulled low; releasing lets the bus pull-up win.
  assign ps2c = r_c_low ? 1'b0 : 1'bz;
  assign ps2d = r_d_low ? 1'b0 : 1'bz;
  assign tx_idle = r_state == S_IDLE;
  assign tx_done_tick = r_done;
  assign tx_err = r_err;
  assign w_d = r_d_sync[1];
  assign w_fall = r_c_filt & ~r_c_sync[1] & (r_fcnt == FW'(FILTER_LEN - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_c_sync <= 2'b11;
      r_d_sync <= 2'b11;
      r_c_filt <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_c_sync <= {r_c_sync[0], ps2c};
      r_d_sync <= {r_d_sync[0], ps2d};
      if (r_c_sync[1] == r_c_filt)
        r_fcnt <= '0;
      else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_c_filt <= r_c_sync[1];
        r_fcnt   <= '0;
      end else
        r_fcnt <= r_fcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_bit   <= '0;
      r_c_low <= 1'b0;
      r_d_low <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (wr_ps2) begin
          r_sr    <= {~^din, din};
          r_bit   <= '0;
          r_cnt   <= '0;
          r_c_low <= 1'b1;
          r_state <= S_RTS;
        end
        S_RTS: begin
          r_cnt <= r_cnt + 32'd1;
          if (r_cnt == 32'(INHIBIT_CYCLES - 2)) r_d_low <= 1'b1;
          if (r_cnt == 32'(INHIBIT_CYCLES - 1)) begin
            r_c_low <= 1'b0;
            r_cnt   <= 32'd1;
            r_state <= S_START;
          end
        end
        default: if (!w_fall && r_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          r_c_low <= 1'b0;
          r_d_low <= 1'b0;
          r_err   <= 1'b1;
          r_state <= S_IDLE;
        end else begin
          r_cnt <= w_fall ? 32'd1 : r_cnt + 32'd1;
          case (r_state)
            S_START, S_DATA: if (w_fall) begin
              r_d_low <= ~r_sr[0];
              r_sr    <= {1'b0, r_sr[8:1]};
              r_bit   <= r_bit + 4'd1;
              r_state <= r_bit == 4'd8 ? S_STOP : S_DATA;
            end
            S_STOP: if (w_fall) begin
              r_d_low <= 1'b0;
              r_state <= S_ACK;
            end
            S_ACK: if (w_fall) begin
              r_err   <= w_d;
              r_state <= w_d ? S_IDLE : S_WREL;
            end
            S_WREL: if (r_c_filt && w_d) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench with a clocking PS/2 device model and a response scoreboard.
module tb_ps2_host_tx;
  localparam int INH = 500;
  localparam int FLT = 8;
  localparam int TMO = 3000;

  typedef struct {
    logic [7:0] d;
    int         kind;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] din = '0;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;
  logic       tx_idle, tx_done, tx_err;
  wire        ps2c, ps2d;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  exp_t       exp_q[$];
  exp_t       e;
  logic [10:0] dev_bits = '0;
  logic       p_done = 1'b0;
  logic       p_err = 1'b0;

  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;
  pullup (ps2c);
  pullup (ps2d);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(rst_n), .wr_ps2(wr), .din(din), .ps2d(ps2d), .ps2c(ps2c),
    .tx_idle(tx_idle), .tx_done_tick(tx_done), .tx_err(tx_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected wire frame in device sampling order: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic p;
    p = ($countones(d) % 2) == 0;
    return {1'b1, p, d, 1'b0};
  endfunction

  initial forever begin
    @(negedge clk);
    if (tx_done || tx_err) begin
      chk("pulse_excl", 32'(tx_done & tx_err), 0);
      chk("pulse_width", 32'((tx_done & p_done) | (tx_err & p_err)), 0);
      if (tx_done) done_cnt++;
      else err_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: done=%b err=%b with no pending transaction", tx_done, tx_err);
      end else begin
        e = exp_q.pop_front();
        chk("resp_is_done", 32'(tx_done), 32'(e.kind == 0));
        if (e.kind != 2) chk("dev_frame", 32'(dev_bits), 32'(frame_of(e.d)));
      end
    end
    p_done = tx_done;
    p_err = tx_err;
  end

  task automatic send(input logic [7:0] d, input int kind, input bit push);
    int n = 0;
    while (!tx_idle && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_before_send", 32'(tx_idle), 1);
    wr = 1'b1;
    din = d;
    if (push) exp_q.push_back('{d, kind});
    @(negedge clk);
    wr = 1'b0;
    din = 8'($urandom);
    chk("idle_drop", 32'(tx_idle), 0);
  endtask

  task automatic dev_frame(input int h, input bit ack, input int glitch_k, input int abort_k);
    int n = 0;
    while (ps2c !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (ps2c === 1'b0 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk("rts_low_cycles", 32'(n), INH);
    for (int k = 0; k <= 10; k++) begin
      if (k == glitch_k) begin
        repeat (h / 2) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (2) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (h - h / 2 - 2) @(negedge clk);
      end else
        repeat (h) @(negedge clk);
      dev_bits[k] = ps2d;
      if (k == abort_k) begin
        dev_c_low = 1'b1;
        repeat (20) @(negedge clk);
        chk("host_drives_d4", 32'(ps2d), 0);
        dev_c_low = 1'b0;
        return;
      end
      if (k == 10 && ack) dev_d_low = 1'b1;
      dev_c_low = 1'b1;
      repeat (h) @(negedge clk);
      dev_c_low = 1'b0;
    end
    repeat (h) @(negedge clk);
    dev_d_low = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!tx_idle && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int d0, e0, l_cyc, n, h;
    logic [7:0] rd;
    bit ack;
    repeat (3) @(negedge clk);
    chk("rst_idle", 32'(tx_idle), 1);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_err", 32'(tx_err), 0);
    chk("rst_lines", 32'({ps2c, ps2d}), 3);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4, 0, 1);
    dev_frame(40, 1, -1, -1);
    wait_idle();
    chk("f4_done_once", 32'(done_cnt - d0), 1);
    chk("f4_no_err", 32'(err_cnt - e0), 0);
    chk("f4_idle", 32'(tx_idle), 1);

    d0 = done_cnt; e0 = err_cnt;
    send(8'h00, 1, 1);
    dev_frame(40, 0, -1, -1);
    wait_idle();
    chk("nack_parity", 32'(dev_bits[9]), 1);
    chk("nack_err_once", 32'(err_cnt - e0), 1);
    chk("nack_no_done", 32'(done_cnt - d0), 0);
    chk("nack_lines", 32'({ps2c, ps2d}), 3);

    e0 = err_cnt;
    send(8'h3C, 2, 1);
    l_cyc = cyc;
    n = 0;
    while (ps2c === 1'b0 && n < 2000) begin
      l_cyc = cyc;
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!tx_err && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_seen", 32'(tx_err), 1);
    chk("timeout_cycles", 32'(cyc - l_cyc), TMO);
    @(negedge clk);
    chk("timeout_lines", 32'({ps2c, ps2d}), 3);
    chk("timeout_idle", 32'(tx_idle), 1);
    chk("timeout_err_once", 32'(err_cnt - e0), 1);

    d0 = done_cnt;
    send(8'hA5, 0, 1);
    dev_frame(40, 1, 4, -1);
    wait_idle();
    chk("glitch_done", 32'(done_cnt - d0), 1);

    d0 = done_cnt; e0 = err_cnt;
    send(8'hAA, 0, 0);
    dev_frame(40, 1, -1, 4);
    #3 rst_n = 1'b0;
    #1 chk("arst_lines", 32'({ps2c, ps2d}), 3);
    chk("arst_idle", 32'(tx_idle), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("arst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 0);
    send(8'hF4, 0, 1);
    dev_frame(40, 1, -1, -1);
    wait_idle();
    chk("post_rst_done", 32'(done_cnt - d0), 1);

    d0 = done_cnt;
    send(8'hF4, 0, 1);
    fork
      dev_frame(40, 1, -1, -1);
      begin
        repeat (INH + 300) @(negedge clk);
        wr = 1'b1;
        din = 8'h55;
        @(negedge clk);
        wr = 1'b0;
      end
    join
    wait_idle();
    chk("midwr_done_once", 32'(done_cnt - d0), 1);

    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      h = $urandom_range(30, 60);
      send(rd, ack ? 0 : 1, 1);
      dev_frame(h, ack, -1, -1);
      wait_idle();
      chk("rand_idle", 32'(tx_idle), 1);
    end

    repeat (10) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: bench did not complete by cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule
